// File: rtl/nn_ctrl_pkg.sv
// rtl/nn_ctrl_pkg.sv - shared modes, scheduler states and index sizing for the NN array controllers
package nn_ctrl_pkg;

    localparam logic [2:0] MODE_IDLE  = 3'd0;
    localparam logic [2:0] MODE_LOAD  = 3'd1;
    localparam logic [2:0] MODE_LAYER = 3'd2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ISSUE_LOAD,
        S_WAIT_LOAD_ON,
        S_WAIT_LOAD_OFF,
        S_ISSUE_LAYER,
        S_WAIT_LAY_ON,
        S_WAIT_LAY_OFF,
        S_WRITEBACK,
        S_ADVANCE,
        S_DONE,
        S_ERROR
    } sched_state_t;

    // At least one bit, even for a single-tile grid.
    function automatic int tile_idx_width(input int n, input int tile);
        int tiles;
        tiles = n / tile;
        return (tiles <= 2) ? 1 : $clog2(tiles);
    endfunction

endpackage

// File: rtl/tile_index_counter_nn.sv
// rtl/tile_index_counter_nn.sv - row/column tile walker, column innermost, with last-tile flag
module tile_index_counter_nn #(
    parameter int TILES = 2,
    parameter int IW    = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          advance,
    output logic [IW-1:0] row,
    output logic [IW-1:0] col,
    output logic          last
);

    localparam logic [IW-1:0] MAX_IDX = IW'(TILES - 1);

    assign last = (row == MAX_IDX) && (col == MAX_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row <= '0;
            col <= '0;
        end else if (clear) begin
            row <= '0;
            col <= '0;
        end else if (advance && !last) begin
            if (col == MAX_IDX) begin
                col <= '0;
                row <= row + IW'(1);
            end else begin
                col <= col + IW'(1);
            end
        end
    end

endmodule

// File: rtl/tile_scheduler_nn.sv
// rtl/tile_scheduler_nn.sv - walks an NxN job tile by tile through load, layer readout and writeback
module tile_scheduler_nn
    import nn_ctrl_pkg::*;
#(
    parameter int N       = 8,
    parameter int TILE    = 4,
    parameter int TIMEOUT = 255,
    localparam int IW     = tile_idx_width(N, TILE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          load_busy,
    input  logic          layer_busy,
    input  logic          wb_ready,
    output logic          load_start,
    output logic          layer_start,
    output logic          wb_valid,
    output logic [2:0]    mode,
    output logic [IW-1:0] row_tile,
    output logic [IW-1:0] col_tile,
    output logic          busy,
    output logic          done,
    output logic          err
);

    sched_state_t state;
    logic [7:0]   timer;
    logic         accept;
    logic         idx_last;
    logic         in_wait;
    logic         wait_exit;
    logic         timed_out;

    assign accept = start && !abort && !load_busy && !layer_busy &&
                    ((state == S_IDLE) || (state == S_ERROR));
    assign in_wait = state inside {S_WAIT_LOAD_ON, S_WAIT_LOAD_OFF, S_WAIT_LAY_ON, S_WAIT_LAY_OFF};
    assign timed_out = (timer == 8'(TIMEOUT - 1));

    always_comb begin
        wait_exit = 1'b0;
        case (state)
            S_WAIT_LOAD_ON:  wait_exit = load_busy;
            S_WAIT_LOAD_OFF: wait_exit = !load_busy;
            S_WAIT_LAY_ON:   wait_exit = layer_busy;
            S_WAIT_LAY_OFF:  wait_exit = !layer_busy;
            default:         wait_exit = 1'b0;
        endcase
    end

    tile_index_counter_nn #(
        .TILES (N / TILE),
        .IW    (IW)
    ) u_idx (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept),
        .advance ((state == S_ADVANCE) && !abort),
        .row     (row_tile),
        .col     (col_tile),
        .last    (idx_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            timer       <= '0;
            load_start  <= 1'b0;
            layer_start <= 1'b0;
            wb_valid    <= 1'b0;
            mode        <= MODE_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            load_start  <= 1'b0;
            layer_start <= 1'b0;
            done        <= 1'b0;
            if (abort && (state != S_IDLE)) begin
                // err is deliberately left alone so a cancelled timeout stays visible
                state    <= S_IDLE;
                timer    <= '0;
                wb_valid <= 1'b0;
                mode     <= MODE_IDLE;
                busy     <= 1'b0;
            end else if (in_wait && !wait_exit) begin
                if (timed_out) begin
                    state <= S_ERROR;
                    timer <= '0;
                    err   <= 1'b1;
                    busy  <= 1'b0;
                    mode  <= MODE_IDLE;
                end else begin
                    timer <= timer + 8'd1;
                end
            end else begin
                timer <= '0;
                case (state)
                    S_IDLE, S_ERROR: begin
                        if (accept) begin
                            state      <= S_ISSUE_LOAD;
                            load_start <= 1'b1;
                            mode       <= MODE_LOAD;
                            busy       <= 1'b1;
                            err        <= 1'b0;
                        end
                    end
                    S_ISSUE_LOAD:    state <= S_WAIT_LOAD_ON;
                    S_WAIT_LOAD_ON:  state <= S_WAIT_LOAD_OFF;
                    S_WAIT_LOAD_OFF: begin
                        state       <= S_ISSUE_LAYER;
                        layer_start <= 1'b1;
                        mode        <= MODE_LAYER;
                    end
                    S_ISSUE_LAYER:   state <= S_WAIT_LAY_ON;
                    S_WAIT_LAY_ON:   state <= S_WAIT_LAY_OFF;
                    S_WAIT_LAY_OFF: begin
                        state    <= S_WRITEBACK;
                        wb_valid <= 1'b1;
                        mode     <= MODE_IDLE;
                    end
                    S_WRITEBACK: begin
                        if (wb_ready) begin
                            state    <= S_ADVANCE;
                            wb_valid <= 1'b0;
                        end
                    end
                    S_ADVANCE: begin
                        if (idx_last) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state      <= S_ISSUE_LOAD;
                            load_start <= 1'b1;
                            mode       <= MODE_LOAD;
                        end
                    end
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tile_scheduler_nn.sv
// tb/tb_tile_scheduler_nn.sv - randomized self-checking bench for tile_scheduler_nn
module tb_tile_scheduler_nn;
    import nn_ctrl_pkg::*;

    localparam int N    = 8;
    localparam int TILE = 4;
    localparam int NT   = N / TILE;
    localparam int IW   = tile_idx_width(N, TILE);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          wb_ready = 1'b1;
    logic          load_busy, layer_busy;
    logic          load_start, layer_start, wb_valid, busy, done, err;
    logic [2:0]    mode;
    logic [IW-1:0] row_tile, col_tile;

    logic ld_bfm = 1'b0;
    logic ly_bfm = 1'b0;
    logic ly_force = 1'b0;
    assign load_busy  = ld_bfm;
    assign layer_busy = ly_bfm | ly_force;

    tile_scheduler_nn #(.N(N), .TILE(TILE), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .load_busy(load_busy), .layer_busy(layer_busy), .wb_ready(wb_ready),
        .load_start(load_start), .layer_start(layer_start), .wb_valid(wb_valid),
        .mode(mode), .row_tile(row_tile), .col_tile(col_tile),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Sub-controller models: busy rises ld_delay cycles after the start pulse, lasts ld_len cycles
    int ld_delay = 1, ld_len = 5, ly_delay = 1, ly_len = 5;
    bit ld_en = 1'b1;
    int ld_cnt = -1, ly_cnt = -1;

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            ld_cnt = -1; ld_bfm = 1'b0;
            ly_cnt = -1; ly_bfm = 1'b0;
        end else begin
            if (load_start && ld_en) ld_cnt = 0;
            else if (ld_cnt >= 0) ld_cnt++;
            ld_bfm = (ld_cnt >= ld_delay) && (ld_cnt < ld_delay + ld_len);
            if (ld_cnt >= ld_delay + ld_len) ld_cnt = -1;
            if (layer_start) ly_cnt = 0;
            else if (ly_cnt >= 0) ly_cnt++;
            ly_bfm = (ly_cnt >= ly_delay) && (ly_cnt < ly_delay + ly_len);
            if (ly_cnt >= ly_delay + ly_len) ly_cnt = -1;
        end
    end

    int wb_mode = 0;
    always @(negedge clk) begin
        case (wb_mode)
            0:       wb_ready = 1'b1;
            1:       wb_ready = ($urandom_range(0, 3) != 0);
            default: wb_ready = 1'b0;
        endcase
    end

    int ld_q[$], ly_q[$], exp_q[$];
    int done_cnt = 0, wb_cnt = 0, mode_bad = 0, pulse_bad = 0;
    logic prev_ls = 1'b0, prev_ys = 1'b0, prev_dn = 1'b0;

    always @(negedge clk) begin
        #1;
        if (load_start) ld_q.push_back(int'(row_tile) * NT + int'(col_tile));
        if (layer_start) ly_q.push_back(int'(row_tile) * NT + int'(col_tile));
        if (done) done_cnt++;
        if (wb_valid && wb_ready) wb_cnt++;
        if (load_start && mode != 3'd1) mode_bad++;
        if (layer_start && mode != 3'd2) mode_bad++;
        if (wb_valid && mode != 3'd0) mode_bad++;
        if ((load_start && prev_ls) || (layer_start && prev_ys) || (done && prev_dn)) pulse_bad++;
        prev_ls = load_start; prev_ys = layer_start; prev_dn = done;
    end

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic clear_obs();
        ld_q.delete(); ly_q.delete();
        done_cnt = 0; wb_cnt = 0; mode_bad = 0; pulse_bad = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (done_cnt == 0 && !err && k < budget) begin
            tick();
            k++;
        end
        chk({tag, " finished in time"}, int'(k < budget), 1);
        repeat (3) tick();
    endtask

    task automatic check_job(input string tag);
        int lm = 0, ym = 0;
        chk({tag, " load count"}, ld_q.size(), NT * NT);
        chk({tag, " layer count"}, ly_q.size(), NT * NT);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= ld_q.size() || ld_q[i] != exp_q[i]) lm++;
            if (i >= ly_q.size() || ly_q[i] != exp_q[i]) ym++;
        end
        chk({tag, " load order"}, lm, 0);
        chk({tag, " layer order"}, ym, 0);
        chk({tag, " done pulses"}, done_cnt, 1);
        chk({tag, " writebacks"}, wb_cnt, NT * NT);
        chk({tag, " mode"}, mode_bad, 0);
        chk({tag, " pulse width"}, pulse_bad, 0);
        chk({tag, " busy after"}, int'(busy), 0);
        chk({tag, " err after"}, int'(err), 0);
    endtask

    task automatic run_job(input string tag);
        clear_obs();
        pulse_start();
        chk({tag, " accepted"}, int'(busy), 1);
        chk({tag, " err cleared"}, int'(err), 0);
        wait_done(tag, 3000);
        check_job(tag);
    endtask

    function automatic int all_outs();
        return int'({load_start, layer_start, wb_valid, busy, done, err, mode, row_tile, col_tile});
    endfunction

    initial begin
        int k, viol;
        for (int r = 0; r < NT; r++)
            for (int c = 0; c < NT; c++)
                exp_q.push_back(r * NT + c);

        #1 rst = 1'b1;
        tick();
        chk("reset outputs", all_outs(), 0);
        @(negedge clk) rst = 1'b0;
        #2;

        run_job("basic");

        for (int it = 0; it < 6; it++) begin
            ld_delay = $urandom_range(0, 3); ld_len = $urandom_range(1, 6);
            ly_delay = $urandom_range(0, 3); ly_len = $urandom_range(1, 6);
            wb_mode = 1;
            run_job($sformatf("random%0d", it));
        end
        wb_mode = 0;
        ld_delay = 1; ld_len = 5; ly_delay = 1; ly_len = 5;
        repeat (3) tick();

        // Writeback stall on tile 1, with a stray start that must be ignored
        clear_obs();
        pulse_start();
        k = 0;
        while (wb_cnt < 1 && k < 200) begin tick(); k++; end
        wb_mode = 2;
        while ((ly_q.size() < 2 || !wb_valid) && k < 400) begin tick(); k++; end
        chk("stall reached", int'(k < 400), 1);
        chk("stall tile", int'(row_tile) * NT + int'(col_tile), 1);
        viol = 0;
        for (int i = 0; i < 20; i++) begin
            start = (i == 5);
            tick();
            if (!wb_valid || load_start || err || !busy) viol++;
        end
        start = 1'b0;
        chk("stall hold", viol, 0);
        chk("stall no new load", ld_q.size(), 2);
        wb_mode = 0;
        k = 0;
        while (!wb_ready && k < 5) begin tick(); k++; end
        k = 0;
        while (!load_start && k < 10) begin tick(); k++; end
        chk("resume latency", k, 2);
        wait_done("stall", 3000);
        check_job("stall");

        // Load controller never responds
        ld_en = 1'b0;
        clear_obs();
        pulse_start();
        chk("timeout issue", int'(load_start), 1);
        k = 0;
        while (!err && k < 400) begin tick(); k++; end
        chk("timeout cycles", k, 256);
        chk("timeout busy", int'(busy), 0);
        chk("timeout mode", int'(mode), 0);
        repeat (5) tick();
        chk("err sticky", int'(err), 1);
        ld_en = 1'b1;
        run_job("after err");

        // Abort while waiting for layer busy to drop on tile 2
        clear_obs();
        pulse_start();
        k = 0;
        while (ly_q.size() < 3 && k < 300) begin tick(); k++; end
        while (!layer_busy && k < 310) begin tick(); k++; end
        chk("abort point", int'(k < 310), 1);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort busy", int'(busy), 0);
        chk("abort mode", int'(mode), 0);
        chk("abort err", int'(err), 0);
        repeat (20) tick();
        chk("abort no done", done_cnt, 0);
        chk("abort no load", ld_q.size(), 3);

        // start held while layer controller is busy
        ly_force = 1'b1;
        clear_obs();
        start = 1'b1;
        viol = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (busy || load_start) viol++;
        end
        chk("start blocked", viol, 0);
        ly_force = 1'b0;
        tick();
        start = 1'b0;
        chk("start after busy", int'(busy), 1);
        wait_done("held start", 3000);
        check_job("held start");

        clear_obs();
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        repeat (3) tick();
        chk("start+abort busy", int'(busy), 0);
        chk("start+abort load", ld_q.size(), 0);

        // Asynchronous reset in the middle of tile 1's load
        clear_obs();
        pulse_start();
        k = 0;
        while ((ld_q.size() < 2 || !load_busy) && k < 300) begin tick(); k++; end
        chk("rst point", int'(busy) + int'(mode), 2);
        @(negedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async rst outputs", all_outs(), 0);
        tick();
        @(negedge clk) rst = 1'b0;
        #2;
        run_job("post rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
